ahbl_sram_adapter: RTL and testbench
====================================

Name: ahbl_sram_adapter

Overview:
- AHB-Lite subordinate that converts bus transfers into cs_n/we_n/be_n/addr/wdata cycles for the sram_wrapper macro array, and returns its rdata to the bus.
- Sits between the bus fabric and one sram_wrapper instance.
- Zero wait states: reads use the SRAM in the address phase; writes are posted through a single-entry write buffer.
- Buffered data is forwarded to later reads of the same word.

Parameters:
- W_DATA, 32: bus and SRAM data width; fixed at 32.
- DEPTH, 512: SRAM depth in words; must match the attached sram_wrapper.
- W_ADDR, 32: AHB address width.
- W_SRAM_ADDR, $clog2(DEPTH): derived SRAM word address width.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ahbls_hready  in  1  bus-wide ready; address phase is sampled only when high.
- ahbls_hready_resp  out  1  subordinate ready; constant 1.
- ahbls_hresp  out  1  constant 0 (OKAY).
- ahbls_haddr  in  W_ADDR  byte address.
- ahbls_hwrite  in  1  1 = write.
- ahbls_htrans  in  2  transfer type; bit 1 set means an active transfer (NONSEQ/SEQ).
- ahbls_hsize  in  3  transfer size: 0 = byte, 1 = halfword, 2 = word.
- ahbls_hwdata  in  W_DATA  write data, valid in the data phase.
- ahbls_hrdata  out  W_DATA  read data, valid in the read data phase.
- sram_cs_n  out  1  active-low chip select.
- sram_we_n  out  1  active-low write enable.
- sram_be_n  out  W_DATA/8  active-low byte enables.
- sram_addr  out  W_SRAM_ADDR  word address.
- sram_wdata  out  W_DATA  SRAM write data.
- sram_rdata  in  W_DATA  SRAM read data, valid one cycle after a read.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Accepted transfer: ahbls_hready & ahbls_htrans[1].
- Word index: haddr[W_SRAM_ADDR+1:2].
- Byte enables from hsize and haddr[1:0], little-endian:
  - byte: one lane.
  - halfword: lanes {1,0} or {3,2}, selected by haddr[1].
  - word: all lanes.
- Registered state:
  - Data-phase write descriptor: dp_wr valid, addr, be.
  - Write buffer: wb_valid, wb_addr, wb_be, wb_data.
  - Read-merge state: dp_rd, merge_mask[3:0], merge_data.
- SRAM port arbitration, evaluated each cycle, highest priority first:
  1. Accepted read address phase: cs_n=0, we_n=1, addr = word index.
  2. Else if wb_valid: commit the buffer (cs_n=0, we_n=0, be_n=~wb_be, wdata=wb_data); clear wb_valid.
  3. Else if dp_wr: write directly from ahbls_hwdata with the dp_wr addr and be.
  4. Else cs_n=1.
- Buffer fill: if dp_wr is set and the SRAM was taken by a read that cycle, load the buffer from dp_wr plus ahbls_hwdata.
- Invariant: the buffer is never valid while its slot is needed for a new write. A write's address-phase cycle never uses the SRAM for a read, so any buffered write commits in that cycle. Assert this invariant in simulation.
- Read forwarding: at a read address phase, compare the read's word index against:
  - the buffer (if wb_valid and it is not being committed), and
  - the in-flight data-phase write (if dp_wr; its data is ahbls_hwdata this cycle).
- If both match, the data-phase write wins on the lanes it covers. Register the per-lane merge_mask and merge_data.
- In the read data phase: hrdata lane i = merge_mask[i] ? merge_data lane i : sram_rdata lane i. Read latency is 0 wait states.
- Outside a read data phase, hrdata is don't-care and is not checked.
- Idle/BUSY htrans and hready-low cycles clear dp_wr/dp_rd at the next edge. They do not disturb a pending buffer, which commits at the first free SRAM cycle.
- Reset values: wb_valid=0, dp_wr=0, dp_rd=0, merge_mask=0, sram_cs_n=1. Reset mid-operation discards a buffered, uncommitted write; this is intended.
- Out-of-range addresses alias modulo DEPTH words. No error response is generated.

Decomposition:
- Shared package ahbl_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
  - HSIZE_BYTE/HALF/WORD constants.
  - Function that decodes hsize and addr[1:0] to a 4-bit byte-enable mask.
- No sub-module. The single write buffer and merge logic are small enough to stay inline.

Test Plan:
- Write word 0xDEADBEEF to 0x10 with idle following → SRAM written in the data-phase cycle directly from hwdata (we_n=0, be_n=4'b0000, addr=4); a later read of 0x10 returns 0xDEADBEEF.
- Write 0x11223344 to 0x20, then back-to-back read of 0x20 → the read occupies the SRAM; the write is buffered; hrdata=0x11223344 via forwarding; the buffer commits on the next idle cycle.
- Byte write 0xAA to 0x23, then read word 0x20 (previously 0x11223344) → hrdata=0xAA223344; merge_mask=4'b1000.
- Write A, read, write B, read, in consecutive cycles → no lost writes; both commit in order; never more than one buffered entry; invariant assertion silent.
- Buffered write pending, then rst=1 for one cycle → wb_valid=0, sram_cs_n=1; memory is not updated by the discarded write.
- Halfword write 0xBEEF to 0x42 → be_n=4'b0011, addr=16; the lower half of word 16 is unchanged.

Source files
------------

// File: rtl/ahbl_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_pkg
//   Shared AHB-Lite definitions for the SRAM adapter: transfer-type and
//   transfer-size encodings, plus the little-endian byte-lane decoder that
//   turns a transfer size and low address bits into a lane mask.
// ---------------------------------------------------------------------------
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    // Lane mask for a 32-bit bus. Bit i set means byte lane i (bits 8i+7:8i)
    // takes part in the transfer. Sizes above a word are treated as a word.
    function automatic logic [3:0] decode_be(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahbl_sram_adapter.sv
// ---------------------------------------------------------------------------
// ahbl_sram_adapter
//   Zero-wait-state AHB-Lite subordinate in front of one synchronous SRAM
//   (sram_wrapper). Reads use the SRAM during their address phase, so the
//   SRAM output arrives exactly in the read data phase. Writes normally go
//   to the SRAM during their data phase straight from hwdata; if a read
//   address phase claims the SRAM in that same cycle, the write is parked in
//   a single-entry buffer and committed at the next free SRAM cycle. Reads
//   of a word that is buffered or still in its write data phase see the new
//   bytes through a per-lane merge.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ahbls_hready        bus-wide ready (address phase sampled when high)
//   ahbls_hready_resp   subordinate ready, always 1
//   ahbls_hresp         always OKAY
//   ahbls_haddr/hwrite/htrans/hsize   address-phase controls
//   ahbls_hwdata        write data (data phase)
//   ahbls_hrdata        read data (read data phase)
//   sram_cs_n/we_n/be_n active-low SRAM controls
//   sram_addr/wdata     SRAM word address and write data
//   sram_rdata          SRAM read data, one cycle after a read
// ---------------------------------------------------------------------------
module ahbl_sram_adapter
    import ahbl_pkg::*;
#(
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 512,
    parameter int W_ADDR      = 32,
    parameter int W_SRAM_ADDR = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   ahbls_hready,
    output logic                   ahbls_hready_resp,
    output logic                   ahbls_hresp,
    input  logic [W_ADDR-1:0]      ahbls_haddr,
    input  logic                   ahbls_hwrite,
    input  logic [1:0]             ahbls_htrans,
    input  logic [2:0]             ahbls_hsize,
    input  logic [W_DATA-1:0]      ahbls_hwdata,
    output logic [W_DATA-1:0]      ahbls_hrdata,

    output logic                   sram_cs_n,
    output logic                   sram_we_n,
    output logic [W_DATA/8-1:0]    sram_be_n,
    output logic [W_SRAM_ADDR-1:0] sram_addr,
    output logic [W_DATA-1:0]      sram_wdata,
    input  logic [W_DATA-1:0]      sram_rdata
);

    localparam int W_BE = W_DATA / 8;

    // Address-phase decode
    logic                   accept;
    logic                   rd_accept;
    logic                   wr_accept;
    logic [W_SRAM_ADDR-1:0] word_index;
    logic [W_BE-1:0]        ap_be;

    // Data-phase write descriptor
    logic                   dp_wr;
    logic [W_SRAM_ADDR-1:0] dp_addr;
    logic [W_BE-1:0]        dp_be;

    // Single-entry write buffer
    logic                   wb_valid;
    logic [W_SRAM_ADDR-1:0] wb_addr;
    logic [W_BE-1:0]        wb_be;
    logic [W_DATA-1:0]      wb_data;
    logic                   wb_commit;

    // Read-merge state
    logic                   dp_rd;
    logic [W_BE-1:0]        merge_mask;
    logic [W_DATA-1:0]      merge_data;
    logic [W_BE-1:0]        next_mask;
    logic [W_DATA-1:0]      next_data;
    logic                   wb_hit;
    logic                   dp_hit;

    // Address bits above the SRAM range alias; htrans[0] only separates
    // NONSEQ from SEQ, which this subordinate treats identically.
    logic unused_bits;
    assign unused_bits = ^{ahbls_haddr[W_ADDR-1:W_SRAM_ADDR+2], ahbls_htrans[0]};

    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;

    assign accept     = ahbls_hready & ahbls_htrans[1];
    assign rd_accept  = accept & ~ahbls_hwrite;
    assign wr_accept  = accept &  ahbls_hwrite;
    assign word_index = ahbls_haddr[W_SRAM_ADDR+1:2];
    assign ap_be      = decode_be(ahbls_hsize, ahbls_haddr[1:0]);

    // SRAM port arbitration. A read address phase always wins so reads never
    // stall; the buffer drains ahead of a direct data-phase write. During
    // reset the port is held idle so a discarded buffer entry never lands.
    always_comb begin
        sram_cs_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = '1;
        sram_addr  = word_index;
        sram_wdata = ahbls_hwdata;
        wb_commit  = 1'b0;
        if (rst) begin
            sram_cs_n = 1'b1;
        end else if (rd_accept) begin
            sram_cs_n = 1'b0;
            sram_be_n = '0;
        end else if (wb_valid) begin
            sram_cs_n  = 1'b0;
            sram_we_n  = 1'b0;
            sram_be_n  = ~wb_be;
            sram_addr  = wb_addr;
            sram_wdata = wb_data;
            wb_commit  = 1'b1;
        end else if (dp_wr) begin
            sram_cs_n  = 1'b0;
            sram_we_n  = 1'b0;
            sram_be_n  = ~dp_be;
            sram_addr  = dp_addr;
        end
    end

    // Forwarding for a read address phase. The in-flight data-phase write is
    // newer than anything buffered, so it takes precedence on its lanes.
    always_comb begin
        next_mask = '0;
        next_data = '0;
        wb_hit    = wb_valid && !wb_commit && (wb_addr == word_index);
        dp_hit    = dp_wr && (dp_addr == word_index);
        for (int i = 0; i < W_BE; i++) begin
            if (dp_hit && dp_be[i]) begin
                next_mask[i]        = 1'b1;
                next_data[8*i +: 8] = ahbls_hwdata[8*i +: 8];
            end else if (wb_hit && wb_be[i]) begin
                next_mask[i]        = 1'b1;
                next_data[8*i +: 8] = wb_data[8*i +: 8];
            end
        end
    end

    // Phase tracking, write buffer and merge registers. Buffer contents and
    // descriptor addresses carry no reset; their valid bits gate them.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_wr      <= 1'b0;
            dp_rd      <= 1'b0;
            wb_valid   <= 1'b0;
            merge_mask <= '0;
        end else begin
            dp_wr      <= wr_accept;
            dp_addr    <= word_index;
            dp_be      <= ap_be;
            dp_rd      <= rd_accept;
            merge_mask <= rd_accept ? next_mask : '0;
            merge_data <= next_data;
            if (dp_wr && rd_accept) begin
                wb_valid <= 1'b1;
                wb_addr  <= dp_addr;
                wb_be    <= dp_be;
                wb_data  <= ahbls_hwdata;
            end else if (wb_commit) begin
                wb_valid <= 1'b0;
            end
        end
    end

    // A write's address phase never reads the SRAM, so any buffered entry
    // drains then; a write in its data phase must find the buffer empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(dp_wr && wb_valid))
                else $error("ahbl_sram_adapter: write buffer occupied during write data phase");
        end
    end

    // Read data: merged lanes come from the forwarding registers.
    always_comb begin
        ahbls_hrdata = '0;
        if (dp_rd) begin
            for (int i = 0; i < W_BE; i++) begin
                ahbls_hrdata[8*i +: 8] = merge_mask[i] ? merge_data[8*i +: 8]
                                                       : sram_rdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahbl_sram_adapter.sv
// ---------------------------------------------------------------------------
// tb_ahbl_sram_adapter
//   Directed bench for the AHB-Lite SRAM adapter with a behavioural
//   synchronous SRAM attached. Each step drives one bus cycle shortly after
//   the rising edge; outputs are sampled once the inputs have settled.
// ---------------------------------------------------------------------------
module tb_ahbl_sram_adapter;
    import ahbl_pkg::*;

    logic        clk;
    logic        rst;
    logic        hready;
    logic        hready_resp;
    logic        hresp;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        sram_cs_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;
    logic [8:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic        init_mem;
    logic [31:0] mem [0:511];

    int checks;
    int errors;

    ahbl_sram_adapter dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready      (hready),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hresp       (hresp),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .sram_cs_n         (sram_cs_n),
        .sram_we_n         (sram_we_n),
        .sram_be_n         (sram_be_n),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_rdata        (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous SRAM: byte-masked writes, registered reads.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        end else if (!sram_cs_n) begin
            if (!sram_we_n) begin
                for (int b = 0; b < 4; b++)
                    if (!sram_be_n[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // Drive one bus cycle: address phase of this step plus the write data
    // belonging to the previous step's address phase.
    task automatic applyStimulus(input logic [1:0] trans, input logic write,
                                 input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic rdy,
                                 input logic rst_val);
        @(posedge clk);
        #1;
        htrans = trans;
        hwrite = write;
        haddr  = addr;
        hsize  = size;
        hwdata = wdata;
        hready = rdy;
        rst    = rst_val;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        init_mem = 1'b1;
        rst      = 1'b1;
        hready   = 1'b1;
        htrans   = HTRANS_IDLE;
        hwrite   = 1'b0;
        haddr    = '0;
        hsize    = HSIZE_WORD;
        hwdata   = '0;

        $display("[TB] reset");
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 1);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 1);
        init_mem = 1'b0;
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("rst_cs_n",       {31'b0, sram_cs_n},     32'h1);
        checkOutput("rst_hready_resp",{31'b0, hready_resp},   32'h1);
        checkOutput("rst_hresp",      {31'b0, hresp},         32'h0);
        checkOutput("rst_wb_valid",   {31'b0, dut.wb_valid},  32'h0);
        checkOutput("rst_merge_mask", {28'b0, dut.merge_mask},32'h0);

        $display("[TB] direct data-phase write");
        applyStimulus(HTRANS_NONSEQ, 1, 32'h10, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t1_ap_cs_n",  {31'b0, sram_cs_n}, 32'h1);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'hDEADBEEF, 1, 0);
        checkOutput("t1_cs_n",  {31'b0, sram_cs_n}, 32'h0);
        checkOutput("t1_we_n",  {31'b0, sram_we_n}, 32'h0);
        checkOutput("t1_be_n",  {28'b0, sram_be_n}, 32'h0);
        checkOutput("t1_addr",  {23'b0, sram_addr}, 32'h4);
        checkOutput("t1_wdata", sram_wdata,         32'hDEADBEEF);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t1_rd_we_n", {31'b0, sram_we_n}, 32'h1);
        checkOutput("t1_rd_addr", {23'b0, sram_addr}, 32'h4);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t1_hrdata", hrdata, 32'hDEADBEEF);

        $display("[TB] write then back-to-back read, forwarded");
        applyStimulus(HTRANS_NONSEQ, 1, 32'h20, HSIZE_WORD, 32'h0, 1, 0);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h20, HSIZE_WORD, 32'h11223344, 1, 0);
        checkOutput("t2_rd_cs_n", {31'b0, sram_cs_n}, 32'h0);
        checkOutput("t2_rd_we_n", {31'b0, sram_we_n}, 32'h1);
        checkOutput("t2_rd_addr", {23'b0, sram_addr}, 32'h8);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t2_hrdata",    hrdata,              32'h11223344);
        checkOutput("t2_commit_we", {31'b0, sram_we_n},  32'h0);
        checkOutput("t2_commit_ad", {23'b0, sram_addr},  32'h8);
        checkOutput("t2_commit_wd", sram_wdata,          32'h11223344);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t2_idle_cs_n", {31'b0, sram_cs_n},  32'h1);

        $display("[TB] byte write merged into word read");
        applyStimulus(HTRANS_NONSEQ, 1, 32'h23, HSIZE_BYTE, 32'h0, 1, 0);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h20, HSIZE_WORD, 32'hAA000000, 1, 0);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t3_merge_mask", {28'b0, dut.merge_mask}, 32'h8);
        checkOutput("t3_hrdata",     hrdata,                  32'hAA223344);
        checkOutput("t3_commit_be",  {28'b0, sram_be_n},      32'h7);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h20, HSIZE_WORD, 32'h0, 1, 0);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t3_readback", hrdata, 32'hAA223344);

        $display("[TB] write/read/write/read interleave");
        applyStimulus(HTRANS_NONSEQ, 1, 32'h30, HSIZE_WORD, 32'h0, 1, 0);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h30, HSIZE_WORD, 32'hA0A0A0A0, 1, 0);
        checkOutput("t4_rd1_addr", {23'b0, sram_addr}, 32'hC);
        applyStimulus(HTRANS_NONSEQ, 1, 32'h34, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t4_hrdata1",  hrdata,             32'hA0A0A0A0);
        checkOutput("t4_cmtA_we",  {31'b0, sram_we_n}, 32'h0);
        checkOutput("t4_cmtA_ad",  {23'b0, sram_addr}, 32'hC);
        checkOutput("t4_cmtA_wd",  sram_wdata,         32'hA0A0A0A0);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h34, HSIZE_WORD, 32'hB0B0B0B0, 1, 0);
        checkOutput("t4_rd2_addr", {23'b0, sram_addr}, 32'hD);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t4_hrdata2",  hrdata,             32'hB0B0B0B0);
        checkOutput("t4_cmtB_ad",  {23'b0, sram_addr}, 32'hD);
        checkOutput("t4_cmtB_wd",  sram_wdata,         32'hB0B0B0B0);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t4_drained",  {31'b0, sram_cs_n}, 32'h1);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h30, HSIZE_WORD, 32'h0, 1, 0);
        applyStimulus(HTRANS_SEQ,    0, 32'h34, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t4_readA", hrdata, 32'hA0A0A0A0);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t4_readB", hrdata, 32'hB0B0B0B0);

        $display("[TB] reset discards pending buffer");
        applyStimulus(HTRANS_NONSEQ, 1, 32'h50, HSIZE_WORD, 32'h0, 1, 0);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h60, HSIZE_WORD, 32'h55555555, 1, 0);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 1);
        checkOutput("t5_rst_cs_n", {31'b0, sram_cs_n}, 32'h1);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t5_wb_valid", {31'b0, dut.wb_valid}, 32'h0);
        checkOutput("t5_cs_n",     {31'b0, sram_cs_n},    32'h1);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t5_mem20",    mem[20],               32'h0);

        $display("[TB] transfer ignored while hready low");
        applyStimulus(HTRANS_NONSEQ, 1, 32'h70, HSIZE_WORD, 32'h0, 0, 0);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h77777777, 1, 0);
        checkOutput("t6_no_write", {31'b0, sram_cs_n}, 32'h1);

        $display("[TB] halfword write to upper half");
        applyStimulus(HTRANS_NONSEQ, 1, 32'h40, HSIZE_WORD, 32'h0, 1, 0);
        applyStimulus(HTRANS_NONSEQ, 1, 32'h42, HSIZE_HALF, 32'h12345678, 1, 0);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'hBEEF0000, 1, 0);
        checkOutput("t7_we_n", {31'b0, sram_we_n}, 32'h0);
        checkOutput("t7_be_n", {28'b0, sram_be_n}, 32'h3);
        checkOutput("t7_addr", {23'b0, sram_addr}, 32'h10);
        applyStimulus(HTRANS_NONSEQ, 0, 32'h40, HSIZE_WORD, 32'h0, 1, 0);
        applyStimulus(HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, 1, 0);
        checkOutput("t7_hrdata", hrdata, 32'hBEEF5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
